// File: rtl/serial_paralelo_param.sv
//==============================================================================
// Module      : serial_paralelo_param
// Description : Single-clock serial-to-parallel converter with comma hunting,
//               word alignment, lock detection and valid-qualified output.
// Revision    : 1.0 - initial parametrised release
//==============================================================================
`default_nettype none

module serial_paralelo_param #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               CW         = $clog2(LOCK_COUNT + 1)
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_strobe,
    output logic             active,
    output logic [CW-1:0]    BC_counter,
    output logic             aligned
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam int             c_bw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_bw-1:0] c_last = c_bw'(WIDTH - 1);
    localparam logic [CW-1:0]  c_lock = CW'(LOCK_COUNT);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_sr;
    logic [c_bw-1:0]  r_bit_cnt, w_bit_cnt_n;
    logic [WIDTH-1:0] r_data, w_data_n;
    logic             r_valid, w_valid_n;
    logic             r_strobe, w_strobe_n;
    logic             r_active, w_active_n;
    logic             r_aligned, w_aligned_n;
    logic [CW-1:0]    r_bc, w_bc_n;

    logic [WIDTH-1:0] w_nxt;
    logic             w_is_comma;
    logic             w_boundary;

    // Candidate word includes the bit being sampled on this edge.
    assign w_nxt      = {r_sr[WIDTH-2:0], data_in};
    assign w_is_comma = (w_nxt == COMMA);
    assign w_boundary = (r_bit_cnt == c_last);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= S_HUNT;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
            r_aligned <= 1'b0;
            r_bc      <= '0;
        end else begin
            r_state   <= w_state_n;
            r_sr      <= w_nxt;
            r_bit_cnt <= w_bit_cnt_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_strobe  <= w_strobe_n;
            r_active  <= w_active_n;
            r_aligned <= w_aligned_n;
            r_bc      <= w_bc_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = (w_boundary) ? '0 : r_bit_cnt + c_bw'(1);
        w_data_n    = r_data;
        w_valid_n   = 1'b0;
        w_strobe_n  = 1'b0;
        w_active_n  = r_active;
        w_aligned_n = r_aligned;
        w_bc_n      = r_bc;

        case (r_state)
            S_HUNT: begin
                w_bit_cnt_n = '0;
                if (w_is_comma) begin
                    w_strobe_n  = 1'b1;
                    w_aligned_n = 1'b1;
                    w_bc_n      = CW'(1);
                    if (LOCK_COUNT == 1) begin
                        w_state_n  = S_LOCKED;
                        w_active_n = 1'b1;
                    end else begin
                        w_state_n = S_ALIGN;
                    end
                end else begin
                    w_bc_n = '0;
                end
            end
            S_ALIGN: begin
                if (w_boundary) begin
                    w_strobe_n = 1'b1;
                    if (w_is_comma) begin
                        w_bc_n = r_bc + CW'(1);
                        if ((r_bc + CW'(1)) == c_lock) begin
                            w_state_n  = S_LOCKED;
                            w_active_n = 1'b1;
                        end
                    end else begin
                        w_state_n   = S_HUNT;
                        w_bc_n      = '0;
                        w_aligned_n = 1'b0;
                    end
                end
            end
            S_LOCKED: begin
                // Lock is sticky: only reset leaves this state.
                if (w_boundary) begin
                    w_strobe_n = 1'b1;
                    if (w_is_comma) begin
                        w_bc_n = c_lock;
                    end else begin
                        w_data_n  = w_nxt;
                        w_valid_n = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_HUNT;
            end
        endcase
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign word_strobe = r_strobe;
    assign active      = r_active;
    assign aligned     = r_aligned;
    assign BC_counter  = r_bc;

endmodule

`default_nettype wire

// File: doc/serial_paralelo_param.md
Name: serial_paralelo_param

Overview:
- Parametrised successor of the fixed 8-bit serial-to-parallel converter.
- Runs on the single bit-rate clock and generates its own word strobe, so no clk_4f is needed.
- Hunts for the comma symbol at any bit offset to find word alignment.
- Declares the link active after LOCK_COUNT consecutive aligned commas, then delivers parallel words with a valid flag.
- Sits at the receive end of the serial lane, feeding the parallel-to-lane logic.

Parameters:
WIDTH, 8, word width in bits (>=4).
COMMA, 8'hBC, alignment/idle symbol (WIDTH bits).
LOCK_COUNT, 4, consecutive aligned commas required to assert active (>=1).
CW, $clog2(LOCK_COUNT+1), width of BC_counter.

Ports:
clk_32f  input  1  bit-rate clock; the only clock.
reset_L  input  1  asynchronous active-low reset.
data_in  input  1  serial bit, MSB of each word first, sampled on rising clk_32f.
data_out  output  WIDTH  last delivered non-comma word (registered).
valid_out  output  1  high for one cycle when data_out is updated with a non-comma word while active.
word_strobe  output  1  one-cycle pulse at every aligned word boundary (ALIGN or LOCKED).
active  output  1  link locked.
BC_counter  output  CW  consecutive aligned commas seen, saturating at LOCK_COUNT.
aligned  output  1  high in ALIGN and LOCKED.

Behaviour:
- Reset (async, reset_L=0): state=HUNT; shift register=0; bit_cnt=0. All outputs are 0: data_out, valid_out, word_strobe, active, BC_counter, aligned. Release is synchronous to the next rising edge.
- Shift register sr[WIDTH-1:0] shifts left every cycle, taking data_in into the LSB.
- nxt = {sr[WIDTH-2:0], data_in} is the candidate word.
- HUNT: each cycle, if nxt==COMMA then: state=ALIGN, bit_cnt=0, BC_counter=1, word_strobe=1 (a one-cycle pulse). Otherwise stay in HUNT with BC_counter=0. Comparison is at every bit offset.
- ALIGN/LOCKED bit counter: bit_cnt counts 0..WIDTH-1 and wraps.
- A word boundary occurs on the cycle where bit_cnt==WIDTH-1, i.e. WIDTH cycles after the previous boundary. At each boundary, word_strobe=1 in the next cycle (registered).
- ALIGN boundary:
  - nxt==COMMA: BC_counter+1. If it reaches LOCK_COUNT, then state=LOCKED and active=1 in the same registered update.
  - nxt!=COMMA: state=HUNT, BC_counter=0, aligned=0. Hunting resumes on the following cycle.
- LOCKED boundary:
  - nxt!=COMMA: data_out=nxt, valid_out=1 for one cycle.
  - nxt==COMMA: data_out holds, valid_out=0, BC_counter saturates at LOCK_COUNT.
  - active and alignment are held until reset. Non-comma words never drop lock.
- Latency: the last bit of a word is sampled on edge N. data_out, valid_out and word_strobe change on edge N+1.
- Valid spacing: valid_out is never high on two consecutive cycles; minimum spacing is WIDTH cycles.
- LOCK_COUNT=1: the first comma found in HUNT goes directly to LOCKED, with active=1 on that update.
- A comma pattern straddling word boundaries while in ALIGN/LOCKED is ignored; only aligned words are compared.
- Reset asserted mid-word or mid-lock clears everything immediately. No partial word is output.

Test Plan:
- Reset: hold reset_L=0 for 5 cycles while toggling data_in -> all outputs 0; after release with data_in=0 for 40 cycles -> state stays HUNT, BC_counter=0.
- Lock (WIDTH=8): send 3 random bits, then 0xBC x4, then 0x5A, 0xC3 -> aligned after the 11th bit; BC_counter steps 1,2,3,4; active=1 one cycle after the 4th comma's last bit; data_out=0x5A then 0xC3, each with a one-cycle valid_out spaced 8 cycles apart.
- Broken preamble: 0xBC,0xBC,0x11,0xBC x4,0x22 -> BC_counter 1,2 then 0 with aligned=0 after 0x11; re-lock on the following commas; data_out=0x22 with valid_out=1.
- Commas while locked: after lock send 0x01,0xBC,0xBC,0x02 -> valid_out pulses only for 0x01 and 0x02; data_out holds 0x01 through the commas; active stays 1; BC_counter=4.
- Reset mid-stream: lock, then assert reset_L=0 asynchronously mid-word (between edges) -> active, aligned and data_out drop to 0 immediately; full re-lock after release.
- Parameter sweep: WIDTH=10, COMMA=10'h17C, LOCK_COUNT=2 -> active after 2 aligned commas; word_strobe period 10 cycles; data 10'h2A5 delivered correctly.
